// File: rtl/mem_inst_sequencer_pkg.sv
// Shared constants, instruction field positions, FSM state encoding and the
// decoded-instruction record for the memory instruction sequencer.
package mem_inst_sequencer_pkg;

  localparam int INST_WIDTH  = 56;
  localparam int ADDR_WIDTH  = 6;
  localparam int NUM_LANES   = 16;
  localparam int LANE_FIELD  = 3;
  localparam int ITER_WIDTH  = 16;
  // Lane fields fill everything above the low opcode/immediate byte.
  localparam int LANES_WIDTH = NUM_LANES * LANE_FIELD;

  // Instruction field positions.
  localparam int IMM_LSB     = 0;
  localparam int IMM_WIDTH   = 4;
  localparam int OPCODE_LSB  = 4;
  localparam int OPCODE_W    = 4;
  localparam int LANES_LSB   = 8;

  localparam logic [3:0] OP_READ  = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0101;
  localparam logic [3:0] OP_WFI   = 4'b0110;
  localparam logic [3:0] OP_LOOP  = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_EXEC,
    ST_WFI_WAIT,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic                   is_read;
    logic                   is_nop;
    logic                   is_shift;
    logic                   is_wfi;
    logic                   is_loop;
    logic                   illegal;
    logic [IMM_WIDTH-1:0]   amount;
    logic [LANES_WIDTH-1:0] lanes;
  } decoded_t;

endpackage

// File: rtl/mem_inst_sequencer_if.sv
// Bundle of the start/wake controls, ROM fetch port, read-request and
// lane-shift handshakes, and status outputs of the sequencer.
interface mem_inst_sequencer_if;
  import mem_inst_sequencer_pkg::*;

  logic                   START;
  logic [ITER_WIDTH-1:0]  NUM_ITER;
  logic                   WAKE;
  logic [ADDR_WIDTH-1:0]  ROM_ADDRESS;
  logic                   ROM_ENABLE;
  logic [INST_WIDTH-1:0]  ROM_DATA;
  logic                   RD_VALID;
  logic                   RD_READY;
  logic                   SHIFT_VALID;
  logic                   SHIFT_READY;
  logic [IMM_WIDTH-1:0]   SHIFT_AMOUNT;
  logic [LANES_WIDTH-1:0] SHIFT_LANES;
  logic                   LOOP_DONE;
  logic [ITER_WIDTH-1:0]  ITER_COUNT;
  logic                   BUSY;
  logic                   ERROR;

  // Environment side: controller, ROM and memory datapath.
  modport master (
    output START, NUM_ITER, WAKE, ROM_DATA, RD_READY, SHIFT_READY,
    input  ROM_ADDRESS, ROM_ENABLE, RD_VALID, SHIFT_VALID, SHIFT_AMOUNT,
           SHIFT_LANES, LOOP_DONE, ITER_COUNT, BUSY, ERROR
  );

  // Sequencer side.
  modport slave (
    input  START, NUM_ITER, WAKE, ROM_DATA, RD_READY, SHIFT_READY,
    output ROM_ADDRESS, ROM_ENABLE, RD_VALID, SHIFT_VALID, SHIFT_AMOUNT,
           SHIFT_LANES, LOOP_DONE, ITER_COUNT, BUSY, ERROR
  );

endinterface

// File: rtl/mem_inst_sequencer_decoder.sv
// Combinational decode of one instruction word into operation flags,
// shift immediate and the per-lane select fields.
module mem_inst_sequencer_decoder
  import mem_inst_sequencer_pkg::*;
(
  input  logic [INST_WIDTH-1:0] inst,
  output decoded_t              dec
);

  logic [OPCODE_W-1:0]    opcode;
  logic [LANES_WIDTH-1:0] lanes_w;

  assign opcode = inst[OPCODE_LSB +: OPCODE_W];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lanes_w[gi*LANE_FIELD +: LANE_FIELD] = inst[LANES_LSB + gi*LANE_FIELD +: LANE_FIELD];
  end

  // Classify the opcode; anything outside the four known codes is illegal.
  always_comb begin
    dec          = '0;
    dec.amount   = inst[IMM_LSB +: IMM_WIDTH];
    dec.lanes    = lanes_w;
    dec.is_read  = (opcode == OP_READ) &&  inst[IMM_LSB];
    dec.is_nop   = (opcode == OP_READ) && !inst[IMM_LSB];
    dec.is_shift = (opcode == OP_SHIFT);
    dec.is_wfi   = (opcode == OP_WFI);
    dec.is_loop  = (opcode == OP_LOOP);
    dec.illegal  = !((opcode == OP_READ) || (opcode == OP_SHIFT) ||
                     (opcode == OP_WFI)  || (opcode == OP_LOOP));
  end

endmodule

// File: rtl/mem_inst_sequencer.sv
// Instruction sequencer: fetches from a 1-cycle-latency ROM, decodes, and
// drives read-request / lane-shift handshakes plus loop bookkeeping.
module mem_inst_sequencer
  import mem_inst_sequencer_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_N,
  mem_inst_sequencer_if.slave  bus
);

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic [ITER_WIDTH-1:0]  num_iter_reg;
  logic [ITER_WIDTH-1:0]  iter_count_reg;
  logic                   last_pass_reg;
  logic                   exec_read_reg, exec_nop_reg, exec_shift_reg;
  logic                   exec_wfi_reg, exec_loop_reg, exec_illegal_reg;
  logic                   rom_enable_reg, rd_valid_reg, shift_valid_reg;
  logic                   loop_done_reg, busy_reg, error_reg;
  logic [ADDR_WIDTH-1:0]  rom_address_reg;
  logic [IMM_WIDTH-1:0]   shift_amount_reg;
  logic [LANES_WIDTH-1:0] shift_lanes_reg;

  decoded_t               dec;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [ITER_WIDTH:0]    iter_plus;
  logic [ITER_WIDTH-1:0]  iter_sat;

  // ROM data is decoded directly so handshake outputs are valid in the
  // first EXEC cycle, keeping the 3-cycle minimum per instruction.
  mem_inst_sequencer_decoder u_decoder (
    .inst (bus.ROM_DATA),
    .dec  (dec)
  );

  assign pc_inc    = pc_reg + 1'b1;                  // wraps at top of program
  assign iter_plus = {1'b0, iter_count_reg} + 1'b1;
  assign iter_sat  = iter_plus[ITER_WIDTH] ? iter_count_reg : iter_plus[ITER_WIDTH-1:0];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= ST_IDLE;
      pc_reg           <= '0;
      num_iter_reg     <= '0;
      iter_count_reg   <= '0;
      last_pass_reg    <= 1'b0;
      exec_read_reg    <= 1'b0;
      exec_nop_reg     <= 1'b0;
      exec_shift_reg   <= 1'b0;
      exec_wfi_reg     <= 1'b0;
      exec_loop_reg    <= 1'b0;
      exec_illegal_reg <= 1'b0;
      rom_enable_reg   <= 1'b0;
      rom_address_reg  <= '0;
      rd_valid_reg     <= 1'b0;
      shift_valid_reg  <= 1'b0;
      shift_amount_reg <= '0;
      shift_lanes_reg  <= '0;
      loop_done_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      rom_enable_reg <= 1'b0;
      loop_done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.START) begin
            num_iter_reg    <= bus.NUM_ITER;
            iter_count_reg  <= '0;
            pc_reg          <= '0;
            rom_address_reg <= '0;
            rom_enable_reg  <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= ST_FETCH;
          end
        end
        ST_FETCH: state_reg <= ST_WAIT_ROM;
        ST_WAIT_ROM: begin
          exec_read_reg    <= dec.is_read;
          exec_nop_reg     <= dec.is_nop;
          exec_shift_reg   <= dec.is_shift;
          exec_wfi_reg     <= dec.is_wfi;
          exec_loop_reg    <= dec.is_loop;
          exec_illegal_reg <= dec.illegal;
          rd_valid_reg     <= dec.is_read;
          shift_valid_reg  <= dec.is_shift;
          if (dec.is_shift) begin
            shift_amount_reg <= dec.amount;
            shift_lanes_reg  <= dec.lanes;
          end
          if (dec.is_loop) begin
            loop_done_reg  <= 1'b1;
            iter_count_reg <= iter_sat;
            last_pass_reg  <= (num_iter_reg != '0) && (iter_plus == {1'b0, num_iter_reg});
          end
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_illegal_reg) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_HALT;
          end else if (exec_wfi_reg) begin
            state_reg <= ST_WFI_WAIT;
          end else if (exec_loop_reg) begin
            if (last_pass_reg) begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              pc_reg          <= '0;
              rom_address_reg <= '0;
              rom_enable_reg  <= 1'b1;
              state_reg       <= ST_FETCH;
            end
          end else if ((exec_read_reg && bus.RD_READY) ||
                       (exec_shift_reg && bus.SHIFT_READY) || exec_nop_reg) begin
            rd_valid_reg    <= 1'b0;
            shift_valid_reg <= 1'b0;
            pc_reg          <= pc_inc;
            rom_address_reg <= pc_inc;
            rom_enable_reg  <= 1'b1;
            state_reg       <= ST_FETCH;
          end
        end
        ST_WFI_WAIT: begin
          if (bus.WAKE) begin
            pc_reg          <= pc_inc;
            rom_address_reg <= pc_inc;
            rom_enable_reg  <= 1'b1;
            state_reg       <= ST_FETCH;
          end
        end
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ROM_ADDRESS  = rom_address_reg;
  assign bus.ROM_ENABLE   = rom_enable_reg;
  assign bus.RD_VALID     = rd_valid_reg;
  assign bus.SHIFT_VALID  = shift_valid_reg;
  assign bus.SHIFT_AMOUNT = shift_amount_reg;
  assign bus.SHIFT_LANES  = shift_lanes_reg;
  assign bus.LOOP_DONE    = loop_done_reg;
  assign bus.ITER_COUNT   = iter_count_reg;
  assign bus.BUSY         = busy_reg;
  assign bus.ERROR        = error_reg;

endmodule

// File: tb/tb_mem_inst_sequencer.sv
// Self-checking bench: an instruction-level reference model predicts every
// output each cycle; directed scenarios plus randomized programs/handshakes.
module tb_mem_inst_sequencer;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  mem_inst_sequencer_if bus ();

  mem_inst_sequencer dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // Registered ROM with one cycle latency.
  logic [55:0] rom [64];
  always @(posedge CLK) if (bus.ROM_ENABLE) bus.ROM_DATA <= rom[bus.ROM_ADDRESS];

  int  errors = 0;
  int  checks = 0;
  bit  rand_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  logic        exp_rom_en, exp_rd, exp_sv, exp_ld, exp_busy, exp_err;
  logic [5:0]  exp_addr;
  logic [3:0]  exp_amt;
  logic [47:0] exp_lanes;
  logic [15:0] exp_iter;
  bit          m_halted;

  task automatic m_zero();
    exp_rom_en = 0; exp_rd = 0; exp_sv = 0; exp_ld = 0; exp_busy = 0; exp_err = 0;
    exp_addr = 0; exp_amt = 0; exp_lanes = 0; exp_iter = 0; m_halted = 0;
  endtask

  task automatic tick(output bit ok);
    @(posedge CLK);
    ok = RESET_N;
  endtask

  // Runs one program from address 0; returns on completion, halt or reset.
  task automatic m_run();
    int          pc;
    logic [15:0] num, iters;
    logic [55:0] w;
    bit          ok;
    num = bus.NUM_ITER; pc = 0; iters = 0; exp_iter = 0; exp_busy = 1;
    forever begin
      exp_rom_en = 1; exp_addr = pc[5:0];
      tick(ok); if (!ok) return;
      exp_rom_en = 0; w = rom[pc];
      tick(ok); if (!ok) return;
      if (w[7:4] == 4'b0000 && w[0]) begin
        exp_rd = 1;
        forever begin tick(ok); if (!ok) return; if (bus.RD_READY) break; end
        exp_rd = 0;
      end else if (w[7:4] == 4'b0000) begin
        tick(ok); if (!ok) return;
      end else if (w[7:4] == 4'b0101) begin
        exp_sv = 1; exp_amt = w[3:0]; exp_lanes = w[55:8];
        forever begin tick(ok); if (!ok) return; if (bus.SHIFT_READY) break; end
        exp_sv = 0;
      end else if (w[7:4] == 4'b0110) begin
        tick(ok); if (!ok) return;
        forever begin tick(ok); if (!ok) return; if (bus.WAKE) break; end
      end else if (w[7:4] == 4'b0111) begin
        exp_ld = 1;
        if (iters != 16'hFFFF) iters = iters + 1;
        exp_iter = iters;
        tick(ok); if (!ok) return;
        exp_ld = 0;
        if (num != 0 && iters == num) begin exp_busy = 0; return; end
        pc = 0;
        continue;
      end else begin
        tick(ok); if (!ok) return;
        exp_err = 1; exp_busy = 0; m_halted = 1;
        return;
      end
      pc = (pc + 1) % 64;
    end
  endtask

  initial begin
    m_zero();
    forever begin
      @(posedge CLK);
      if (!RESET_N) m_zero();
      else if (!m_halted && bus.START) begin
        m_run();
        if (!RESET_N) m_zero();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (!RESET_N) begin
      chk("rst_rom_en", 64'(bus.ROM_ENABLE), 64'(0));
      chk("rst_rd_valid", 64'(bus.RD_VALID), 64'(0));
      chk("rst_shift_valid", 64'(bus.SHIFT_VALID), 64'(0));
      chk("rst_busy", 64'(bus.BUSY), 64'(0));
      chk("rst_error", 64'(bus.ERROR), 64'(0));
      chk("rst_iter", 64'(bus.ITER_COUNT), 64'(0));
      chk("rst_addr", 64'(bus.ROM_ADDRESS), 64'(0));
    end else begin
      chk("rom_enable", 64'(bus.ROM_ENABLE), 64'(exp_rom_en));
      if (exp_rom_en) chk("rom_address", 64'(bus.ROM_ADDRESS), 64'(exp_addr));
      chk("rd_valid", 64'(bus.RD_VALID), 64'(exp_rd));
      chk("shift_valid", 64'(bus.SHIFT_VALID), 64'(exp_sv));
      if (exp_sv) begin
        chk("shift_amount", 64'(bus.SHIFT_AMOUNT), 64'(exp_amt));
        chk("shift_lanes", 64'(bus.SHIFT_LANES), 64'(exp_lanes));
      end
      chk("loop_done", 64'(bus.LOOP_DONE), 64'(exp_ld));
      chk("iter_count", 64'(bus.ITER_COUNT), 64'(exp_iter));
      chk("busy", 64'(bus.BUSY), 64'(exp_busy));
      chk("error", 64'(bus.ERROR), 64'(exp_err));
    end
  end

  // Transaction log and counters.
  int rd_cnt = 0, sh_cnt = 0, ld_cnt = 0;
  always @(posedge CLK) begin
    if (RESET_N && bus.RD_VALID && bus.RD_READY) begin
      rd_cnt <= rd_cnt + 1;
      $display("%0t read accepted", $time);
    end
    if (RESET_N && bus.SHIFT_VALID && bus.SHIFT_READY) begin
      sh_cnt <= sh_cnt + 1;
      $display("%0t shift accepted amount=%0d lanes=%0h", $time, bus.SHIFT_AMOUNT, bus.SHIFT_LANES);
    end
    if (RESET_N && bus.LOOP_DONE) begin
      ld_cnt <= ld_cnt + 1;
      $display("%0t loop done iter=%0d", $time, bus.ITER_COUNT);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge CLK);
    if (rand_mode) begin
      bus.RD_READY    = 1'($urandom_range(0, 1));
      bus.SHIFT_READY = 1'($urandom_range(0, 1));
      bus.WAKE        = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 56'h0;
  endtask

  task automatic pulse_start();
    bus.START = 1; cyc(); bus.START = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.BUSY && n < max) begin cyc(); n++; end
    chk("idle_timeout", 64'(bus.BUSY), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge CLK); #2; RESET_N = 0;
    @(negedge CLK); @(negedge CLK); RESET_N = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0, ld0, seen, n, prev_addr;
    bit          wrapped, found;
    logic [47:0] lanes_lit;
    logic [47:0] rl;

    bus.START = 0; bus.NUM_ITER = 0; bus.WAKE = 0; bus.RD_READY = 0; bus.SHIFT_READY = 0;
    clear_rom();
    #1 RESET_N = 0;
    @(negedge CLK); @(negedge CLK); RESET_N = 1;
    cyc();

    // 1: READ + LOOP, two passes, READY tied high.
    clear_rom(); rom[0] = 56'h01; rom[1] = 56'h70;
    bus.NUM_ITER = 2; bus.RD_READY = 1;
    rd0 = rd_cnt; ld0 = ld_cnt;
    pulse_start(); wait_idle(200); cyc();
    chk("t1_iter_count", 64'(bus.ITER_COUNT), 64'(2));
    chk("t1_busy", 64'(bus.BUSY), 64'(0));
    chk("t1_reads", 64'(rd_cnt - rd0), 64'(2));
    chk("t1_loops", 64'(ld_cnt - ld0), 64'(2));

    // 2: SHIFT amount 15, lanes 1..4 = 3'b100, READY low for 5 cycles.
    lanes_lit = '0;
    for (int k = 1; k <= 4; k++) lanes_lit[3*k +: 3] = 3'b100;
    clear_rom(); rom[0] = {lanes_lit, 8'h5F}; rom[1] = 56'h70;
    bus.NUM_ITER = 1; bus.SHIFT_READY = 0;
    pulse_start();
    n = 0; while (!bus.SHIFT_VALID && n < 20) begin cyc(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", 64'(bus.SHIFT_VALID), 64'(1));
      chk("t2_amount", 64'(bus.SHIFT_AMOUNT), 64'(15));
      chk("t2_lanes", 64'(bus.SHIFT_LANES), 64'(lanes_lit));
      cyc();
    end
    bus.SHIFT_READY = 1; cyc();
    chk("t2_fetch_next", 64'({bus.ROM_ENABLE, bus.ROM_ADDRESS}), 64'({1'b1, 6'd1}));
    bus.SHIFT_READY = 0;
    wait_idle(50); cyc();

    // 3: WFI at address 1; early WAKE dropped, second WAKE releases.
    clear_rom(); rom[1] = 56'h60; rom[2] = 56'h70;
    bus.NUM_ITER = 1;
    bus.START = 1; cyc(); bus.START = 0; bus.WAKE = 1; cyc(); bus.WAKE = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ROM_ENABLE && bus.ROM_ADDRESS == 6'd2) seen++;
      cyc();
    end
    chk("t3_no_early_fetch", 64'(seen), 64'(0));
    chk("t3_busy_waiting", 64'(bus.BUSY), 64'(1));
    bus.WAKE = 1; cyc(); bus.WAKE = 0;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ROM_ENABLE && bus.ROM_ADDRESS == 6'd2) found = 1;
      cyc();
    end
    chk("t3_fetch_after_wake", 64'(found), 64'(1));
    wait_idle(50); cyc();

    // 4: illegal opcode at address 3 halts.
    clear_rom(); rom[3] = 56'hF0;
    bus.NUM_ITER = 1;
    pulse_start();
    n = 0; while (!bus.ERROR && n < 50) begin cyc(); n++; end
    cyc();
    chk("t4_error", 64'(bus.ERROR), 64'(1));
    chk("t4_busy", 64'(bus.BUSY), 64'(0));
    pulse_start();
    seen = 0;
    for (int i = 0; i < 6; i++) begin if (bus.ROM_ENABLE) seen++; cyc(); end
    chk("t4_no_fetch", 64'(seen), 64'(0));
    chk("t4_error_sticky", 64'(bus.ERROR), 64'(1));
    do_reset(); cyc();

    // 5a: 64 NOPs, address wraps 63 -> 0.
    clear_rom(); bus.NUM_ITER = 0;
    pulse_start();
    wrapped = 0; prev_addr = -1;
    for (int i = 0; i < 64*3 + 12; i++) begin
      if (bus.ROM_ENABLE) begin
        if (prev_addr == 63 && bus.ROM_ADDRESS == 6'd0) wrapped = 1;
        prev_addr = int'(bus.ROM_ADDRESS);
      end
      cyc();
    end
    chk("t5_wrap", 64'(wrapped), 64'(1));
    do_reset(); cyc();

    // 5b: NUM_ITER = 0 keeps looping.
    clear_rom(); rom[1] = 56'h70; bus.NUM_ITER = 0;
    pulse_start();
    for (int i = 0; i < 70; i++) cyc();
    chk("t5_many_passes", 64'(bus.ITER_COUNT >= 16'd10), 64'(1));
    chk("t5_still_busy", 64'(bus.BUSY), 64'(1));
    do_reset(); cyc();

    // 6: reset while a read is pending.
    clear_rom(); rom[0] = 56'h01; bus.NUM_ITER = 1; bus.RD_READY = 0;
    pulse_start();
    n = 0; while (!bus.RD_VALID && n < 20) begin cyc(); n++; end
    chk("t6_rd_pending", 64'(bus.RD_VALID), 64'(1));
    rd0 = rd_cnt;
    @(posedge CLK); #2; RESET_N = 0; #1;
    chk("t6_rd_async_drop", 64'(bus.RD_VALID), 64'(0));
    chk("t6_busy_async_drop", 64'(bus.BUSY), 64'(0));
    @(negedge CLK); @(negedge CLK); RESET_N = 1;
    bus.RD_READY = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin if (bus.ROM_ENABLE || bus.RD_VALID) seen++; cyc(); end
    chk("t6_idle_after", 64'(seen), 64'(0));
    chk("t6_no_replay", 64'(rd_cnt - rd0), 64'(0));

    // 7: randomized legal programs with random handshakes and wakes.
    for (int r = 0; r < 4; r++) begin
      int len;
      clear_rom();
      len = $urandom_range(3, 10);
      for (int i = 0; i < len - 1; i++) begin
        rl = {16'($urandom), 32'($urandom)};
        case ($urandom_range(0, 3))
          0: rom[i] = {rl, 4'h0, 3'($urandom), 1'b1};
          1: rom[i] = {rl, 4'h0, 3'($urandom), 1'b0};
          2: rom[i] = {rl, 4'h5, 4'($urandom)};
          default: rom[i] = {rl, 8'h60};
        endcase
      end
      rom[len-1] = 56'h70;
      bus.NUM_ITER = 16'($urandom_range(1, 3));
      rand_mode = 1;
      pulse_start();
      wait_idle(4000);
      rand_mode = 0; bus.WAKE = 0; bus.RD_READY = 0; bus.SHIFT_READY = 0;
      cyc(); cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
